// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and stall controller: picks the PC load value, merges
// load-use and mult/div busy stalls, and holds redirects that arrive mid-stall.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h00003000,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_cur,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        lw_hazard,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        stall,
  output logic        md_busy,
  output logic [3:0]  md_count
);

  localparam logic [3:0] MULT_CNT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_CYCLES[3:0];

  logic [3:0]  r_md_count;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic        w_busy;
  logic        w_stall;
  logic        w_new_redir;
  logic [31:0] w_new_target;
  logic [31:0] w_seq_pc;

  assign w_busy       = (r_md_count != 4'd0);
  assign w_stall      = lw_hazard | (md_use & w_busy);
  assign w_new_redir  = jump | br_taken;
  assign w_new_target = jump ? jump_target : br_target;
  assign w_seq_pc     = pc_cur + 32'd4;

  assign md_busy  = w_busy;
  assign md_count = r_md_count;

  // Holding pc_cur while stalled keeps the PC stable even if pc_en is ignored.
  always_comb begin
    next_pc = w_seq_pc;
    pc_en   = 1'b1;
    stall   = 1'b0;
    if (Reset) begin
      next_pc = RESET_PC;
    end else if (w_stall) begin
      next_pc = pc_cur;
      pc_en   = 1'b0;
      stall   = 1'b1;
    end else if (w_new_redir) begin
      next_pc = w_new_target;
    end else if (r_pend_valid) begin
      next_pc = r_pend_target;
    end
  end

  // A start while already busy is dropped; the issuing instruction is held by stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_md_count <= 4'd0;
    end else if (md_start && !w_busy) begin
      r_md_count <= md_is_div ? DIV_CNT : MULT_CNT;
    end else if (w_busy) begin
      r_md_count <= r_md_count - 4'd1;
    end
  end

  // Latest redirect seen during a stall wins; any unstalled cycle consumes it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else if (w_stall) begin
      if (w_new_redir) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_new_target;
      end
    end else begin
      r_pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: driver pushes model expectations per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h00003000;

  logic        Clk = 1'b0;
  logic        Reset, br_taken, jump, lw_hazard, md_start, md_is_div, md_use;
  logic [31:0] pc_cur, br_target, jump_target, next_pc;
  logic        pc_en, stall, md_busy;
  logic [3:0]  md_count;

  pc_seq_ctrl #(.RESET_PC(RST_PC), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .pc_cur(pc_cur), .br_taken(br_taken),
    .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .lw_hazard(lw_hazard), .md_start(md_start), .md_is_div(md_is_div),
    .md_use(md_use), .next_pc(next_pc), .pc_en(pc_en), .stall(stall),
    .md_busy(md_busy), .md_count(md_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] npc;
    logic        en;
    logic        stl;
    logic        busy;
    logic [3:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: busy window as an absolute end cycle, pending as a queue.
  int cyc = 0;
  int busy_end = -1;
  logic [31:0] pend_q[$];

  task automatic step(input bit rst, input logic [31:0] pc,
                      input bit bt, input logic [31:0] bta,
                      input bit j, input logic [31:0] jt,
                      input bit lw, input bit ms, input bit mdiv, input bit mu);
    exp_t e;
    int cnt;
    bit redir;
    logic [31:0] tgt;
    @(posedge Clk);
    #1;
    Reset = rst; pc_cur = pc; br_taken = bt; br_target = bta; jump = j;
    jump_target = jt; lw_hazard = lw; md_start = ms; md_is_div = mdiv; md_use = mu;
    cnt = (cyc <= busy_end) ? (busy_end - cyc + 1) : 0;
    e.cnt = cnt[3:0];
    e.busy = (cnt > 0);
    e.cyc = cyc;
    if (rst) begin
      e.npc = RST_PC; e.en = 1'b1; e.stl = 1'b0;
      busy_end = -1;
      pend_q.delete();
    end else begin
      redir = j | bt;
      tgt = j ? jt : bta;
      e.stl = lw | (mu & (cnt > 0));
      if (e.stl) begin
        e.npc = pc; e.en = 1'b0;
        if (redir) begin
          pend_q.delete();
          pend_q.push_back(tgt);
        end
      end else begin
        e.en = 1'b1;
        if (redir) e.npc = tgt;
        else if (pend_q.size() > 0) e.npc = pend_q[0];
        else e.npc = pc + 32'd4;
        pend_q.delete();
      end
      if (ms && cnt == 0) busy_end = cyc + (mdiv ? 10 : 5);
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input logic [31:0] pc, input bit mu);
    step(0, pc, 0, 32'h0, 0, 32'h0, 0, 0, 0, mu);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic cmp(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h required %h", name, c, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("next_pc", e.cyc, next_pc, e.npc);
      cmp("pc_en", e.cyc, {31'd0, pc_en}, {31'd0, e.en});
      cmp("stall", e.cyc, {31'd0, stall}, {31'd0, e.stl});
      cmp("md_busy", e.cyc, {31'd0, md_busy}, {31'd0, e.busy});
      cmp("md_count", e.cyc, {28'd0, md_count}, {28'd0, e.cnt});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; pc_cur = 0; br_taken = 0; br_target = 0; jump = 0; jump_target = 0;
    lw_hazard = 0; md_start = 0; md_is_div = 0; md_use = 0;

    // Reset held two cycles, then release.
    step(1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 lit("rst_npc", next_pc, RST_PC);
    lit("rst_en", {31'd0, pc_en}, 32'd1);
    step(1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(32'h1234, 0);
    #2 lit("post_rst_npc", next_pc, 32'h1238);
    lit("post_rst_busy", {31'd0, md_busy}, 32'd0);

    // Multiply then divide with md_use held.
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 5 : 10;
      step(0, 32'h2000, 0, 0, 0, 0, 0, 1, k[0], 1);
      for (int i = 0; i < n; i++) begin
        idle(32'h2004, 1);
        #2 lit("md_cnt", {28'd0, md_count}, n - i);
        lit("md_stall", {31'd0, stall}, 32'd1);
      end
      idle(32'h2004, 1);
      #2 lit("md_done_stall", {31'd0, stall}, 32'd0);
      lit("md_done_en", {31'd0, pc_en}, 32'd1);
    end

    // Branch during load-use stall is held then applied.
    step(0, 32'h3010, 1, 32'h3400, 0, 0, 1, 0, 0, 0);
    #2 lit("lw_hold_npc", next_pc, 32'h3010);
    lit("lw_hold_en", {31'd0, pc_en}, 32'd0);
    idle(32'h3010, 0);
    #2 lit("pend_apply", next_pc, 32'h3400);
    idle(32'h3400, 0);
    #2 lit("pend_clear", next_pc, 32'h3404);

    // Fresh jump on unstall cycle beats pending branch; jump beats branch.
    step(0, 32'h3010, 1, 32'h3400, 0, 0, 1, 0, 0, 0);
    step(0, 32'h3010, 0, 0, 1, 32'h3800, 0, 0, 0, 0);
    #2 lit("jump_wins", next_pc, 32'h3800);
    idle(32'h3800, 0);
    #2 lit("pend_dropped", next_pc, 32'h3804);
    step(0, 32'h3804, 1, 32'h3400, 1, 32'h3900, 0, 0, 0, 0);
    #2 lit("jump_over_br", next_pc, 32'h3900);

    // PC wrap.
    idle(32'hFFFF_FFFC, 0);
    #2 lit("wrap", next_pc, 32'h0);

    // Reset mid-divide with a pending redirect.
    step(0, 32'h4000, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h4004, 1, 32'h5555_0000, 0, 0, 1, 0, 0, 1);
    step(1, 32'h4004, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 lit("rst_cnt7", {28'd0, md_count}, 32'd7);
    idle(32'h4000, 0);
    #2 lit("abort_cnt", {28'd0, md_count}, 32'd0);
    lit("abort_busy", {31'd0, md_busy}, 32'd0);
    lit("abort_npc", next_pc, 32'h4004);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 40) == 0, pc,
           $urandom_range(0, 4) == 0, $urandom,
           $urandom_range(0, 6) == 0, $urandom,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0);
    end

    begin
      int waited;
      waited = 0;
      while (q.size() > 0 && waited < 10) begin
        @(posedge Clk);
        waited++;
      end
      @(posedge Clk);
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL drain: got %0d left required 0", q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC sequencer and stall controller for the multi-cycle CPU. Each cycle it selects the value the PC register loads (sequential PC+4, branch target, jump target or reset vector) and the enable that gates the load. It combines load-use hazards with a multiply/divide busy counter into one stall. A redirect that arrives during a stall is held and applied on the first unstalled cycle.

## Interface

- RESET_PC, 32'h00003000, vector presented on next_pc during reset
- MULT_CYCLES, 5, busy duration of a multiply (1..15)
- DIV_CYCLES, 10, busy duration of a divide (1..15)

- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk
- pc_cur  in  32  current PC register value
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  32  branch target address
- jump  in  1  j/jal/jr resolved this cycle
- jump_target  in  32  jump target address
- lw_hazard  in  1  load-use hazard detected in decode
- md_start  in  1  mult/div issued this cycle
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
- md_use  in  1  decode instruction touches HI/LO or is itself a mult/div
- next_pc  out  32  value for the PC register to load
- pc_en  out  1  PC write enable
- stall  out  1  pipeline front-end stall
- md_busy  out  1  mult/div unit occupied
- md_count  out  4  remaining busy cycles

## Operation

- Reset (Reset=1 at edge): md_count←0, pend_valid←0, pend_target←0. While Reset is high, combinationally next_pc=RESET_PC and pc_en=1. stall is forced 0 and md_busy follows md_count.
- md_busy = (md_count != 0). stall = lw_hazard | (md_use & md_busy). pc_en = ~stall when Reset is low.
- Busy counter:
  - md_start & ~md_busy: md_count←(md_is_div ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, if md_count != 0: md_count←md_count-1.
  - md_start while busy is ignored; it coincides with md_use, so stall holds the issuing instruction.
- Redirect source priority, highest first: jump, br_taken, pending, sequential.
  - new_redir = jump | br_taken. new_target = jump ? jump_target : br_target.
  - Unstalled: next_pc = new_redir ? new_target : (pend_valid ? pend_target : pc_cur+4). pend_valid←0.
  - Stalled: next_pc = pc_cur, so the hold is harmless even if the PC ignores pc_en. If new_redir, pend_valid←1 and pend_target←new_target; a newer redirect overwrites the older one. Otherwise pending is unchanged.
- pc_cur+4 is modulo 2^32: 32'hFFFFFFFC → 32'h00000000. No alignment checks.

## Timing

- next_pc, pc_en and stall are combinational from the current-cycle inputs and state, with zero latency.
- md_start sampled at edge t:
  - md_count=N during cycle t+1 down to 1 during cycle t+N.
  - md_busy is low again from cycle t+N+1.
- A redirect captured while stalled appears on next_pc in the first cycle with stall=0, unless a fresh redirect is present that cycle, in which case the fresh one wins and the pending one is discarded.
- Reset asserted mid-operation aborts the busy count and drops any pending redirect at that edge; the first post-reset cycle behaves as idle.
- lw_hazard and md stall in the same cycle give one stall; there is no extra penalty.

## Test plan

- Reset held 2 cycles, pc_cur=32'h1234 → next_pc=32'h00003000 and pc_en=1 during reset. After release with no other inputs → next_pc=32'h1238, md_busy=0.
- md_start with md_is_div=0 at edge t, md_use held 1 → md_count 5,4,3,2,1 over cycles t+1..t+5 with stall=1. At t+6, stall=0 and pc_en=1. Repeat with md_is_div=1 → 10 cycles of stall.
- lw_hazard=1 and br_taken=1 with br_target=32'h3400 in the same cycle, pc_cur=32'h3010 → next_pc=32'h3010 and pc_en=0. The following unstalled cycle gives next_pc=32'h3400, then pend_valid clears.
- Pending branch 32'h3400 plus, on the unstall cycle, jump=1 with jump_target=32'h3800 → next_pc=32'h3800, and the pending redirect is discarded. jump and br_taken together → the jump target is selected.
- pc_cur=32'hFFFFFFFC, no redirect → next_pc=32'h00000000.
- Reset asserted while md_count=7 with a pending redirect → md_count=0 and md_busy=0 next cycle. After release, next_pc=pc_cur+4, not the stale target.
